// File: rtl/rvbmu_pkg.sv
// Shared types and helpers for the sequential bit-extract/deposit unit.
// Op encodings, FSM states and elaboration-time width functions.
package rvbmu_pkg;

    localparam logic OP_BEXT = 1'b0;
    localparam logic OP_BDEP = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        EXE,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int stage_width(input int xlen, input int s);
        return xlen >> (s + 1);
    endfunction

endpackage

// File: rtl/rvbmu_seq_stage.sv
// One butterfly stage with a runtime-selected stride.
// Generate mode derives per-block control; execute mode merges or splits halves.
module rvbmu_seq_stage
    import rvbmu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int L    = clog2(XLEN),
    localparam int SW   = clog2(L),
    localparam int HALF = XLEN / 2
) (
    input  logic            gen,
    input  logic            op,
    input  logic [SW-1:0]   sel,
    input  logic [XLEN-1:0] mask,
    input  logic [XLEN-1:0] data_in,
    input  logic [HALF-1:0] ctl_in,
    output logic [XLEN-1:0] data_out,
    output logic [HALF-1:0] ctl_out
);

    logic [XLEN-1:0] cand_d [L];
    logic [HALF-1:0] cand_c [L];

    // Control per block is the set-bit count of its lower half; it packs
    // into HALF bits for every stride, so one store row fits any stage.
    for (genvar t = 0; t < L; t++) begin : g_stride
        localparam int H  = 1 << t;
        localparam int B  = 2 * H;
        localparam int NB = stage_width(XLEN, t);
        localparam int CW = t + 1;

        logic [CW-1:0]   k;
        logic [B-1:0]    lo;
        logic [B-1:0]    hi;
        logic [B-1:0]    blk;
        logic [XLEN-1:0] d_o;
        logic [HALF-1:0] c_o;

        always_comb begin
            d_o = '0;
            c_o = '0;
            k   = '0;
            lo  = '0;
            hi  = '0;
            blk = '0;
            for (int b = 0; b < NB; b++) begin
                k = '0;
                for (int j = 0; j < H; j++)
                    k = k + CW'(mask[b*B+j]);
                c_o[b*CW +: CW] = k;
                if (!gen)
                    k = ctl_in[b*CW +: CW];
                if (op == OP_BEXT) begin
                    lo = B'(data_in[b*B +: H]);
                    hi = B'(data_in[b*B+H +: H]);
                    d_o[b*B +: B] = lo | (hi << k);
                end else begin
                    blk = data_in[b*B +: B];
                    lo  = blk & ((B'(1) << k) - B'(1));
                    hi  = blk >> k;
                    d_o[b*B +: H]   = lo[H-1:0];
                    d_o[b*B+H +: H] = hi[H-1:0];
                end
            end
        end

        assign cand_d[t] = d_o;
        assign cand_c[t] = c_o;
    end

    always_comb begin
        data_out = data_in;
        ctl_out  = '0;
        for (int t = 0; t < L; t++) begin
            if (int'(sel) == t) begin
                if (gen)
                    ctl_out = cand_c[t];
                else
                    data_out = cand_d[t];
            end
        end
    end

endmodule

// File: rtl/rvbmu_seq.sv
// Multicycle bext/bdep unit: SPC butterfly stages per cycle,
// with the last mask's control bits cached to skip regeneration.
module rvbmu_seq
    import rvbmu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SPC      = 1,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_op,
    input  logic [XLEN-1:0] in_data,
    input  logic [XLEN-1:0] in_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_hit
);

    localparam int L    = clog2(XLEN);
    localparam int P    = L / SPC;
    localparam int HALF = XLEN / 2;
    localparam int SW   = clog2(L);
    localparam int CNTW = (P > 1) ? clog2(P) : 1;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            op_q;
    logic [XLEN-1:0] mask_q;
    logic [XLEN-1:0] acc;
    logic            hit_q;
    logic            cache_vld;
    logic            cache_op;
    logic [XLEN-1:0] cache_mask;
    logic [HALF-1:0] ctl_q [L];
    logic [HALF-1:0] gen_ctl [SPC];
    logic [XLEN-1:0] chain_out;
    logic            hit;
    logic            last;

    assign last     = (cnt == CNTW'(P - 1));
    assign in_ready = (state == IDLE) && !reset;
    assign hit      = CACHE_EN && cache_vld &&
                      (in_mask == cache_mask) && (in_op == cache_op);

    for (genvar j = 0; j < SPC; j++) begin : g_chain
        logic [SW-1:0]   s;
        logic [HALF-1:0] c_i;
        logic [HALF-1:0] c_o;
        logic [XLEN-1:0] d_i;
        logic [XLEN-1:0] d_o;

        if (j == 0) begin : g_head
            assign d_i = acc;
        end else begin : g_link
            assign d_i = g_chain[j-1].d_o;
        end

        // Deposit walks the network top-down, extract bottom-up.
        always_comb begin
            s = SW'(int'(cnt) * SPC + j);
            if (state == EXE && op_q == OP_BDEP)
                s = SW'(L - 1 - int'(cnt) * SPC - j);
            c_i = '0;
            for (int t = 0; t < L; t++)
                if (int'(s) == t) c_i = ctl_q[t];
        end

        rvbmu_seq_stage #(
            .XLEN(XLEN)
        ) u_stage (
            .gen     (state == GEN),
            .op      (op_q),
            .sel     (s),
            .mask    (mask_q),
            .data_in (d_i),
            .ctl_in  (c_i),
            .data_out(d_o),
            .ctl_out (c_o)
        );

        assign gen_ctl[j] = c_o;
    end

    assign chain_out = g_chain[SPC-1].d_o;

    always_ff @(posedge clk) begin
        if (!reset && state == GEN) begin
            for (int j = 0; j < SPC; j++)
                for (int t = 0; t < L; t++)
                    if (int'(cnt) * SPC + j == t) ctl_q[t] <= gen_ctl[j];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= OP_BEXT;
            mask_q     <= '0;
            acc        <= '0;
            hit_q      <= 1'b0;
            cache_vld  <= 1'b0;
            cache_op   <= OP_BEXT;
            cache_mask <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_hit    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_op;
                        mask_q <= in_mask;
                        acc    <= (in_op == OP_BEXT) ? (in_data & in_mask)
                                                     : in_data;
                        cnt    <= '0;
                        hit_q  <= hit;
                        state  <= hit ? EXE : GEN;
                    end
                end
                GEN: begin
                    cnt <= last ? '0 : cnt + CNTW'(1);
                    if (last) begin
                        cache_vld  <= 1'b1;
                        cache_mask <= mask_q;
                        cache_op   <= op_q;
                        state      <= EXE;
                    end
                end
                EXE: begin
                    acc <= chain_out;
                    cnt <= last ? '0 : cnt + CNTW'(1);
                    if (last) begin
                        out_valid <= 1'b1;
                        out_data  <= (op_q == OP_BDEP) ? (chain_out & mask_q)
                                                       : chain_out;
                        out_hit   <= hit_q;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvbmu_seq.sv
// Scoreboard bench for rvbmu_seq: XLEN=32/SPC=1 directed cases,
// then XLEN=64/SPC=2 random traffic with output stalls.
module tb_rvbmu_seq;

    localparam int P32 = 5;
    localparam int P64 = 3;

    typedef struct {
        logic [63:0] data;
        logic        hit;
        int          lat;
        int          t_acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_op = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] in_mask = '0;
    logic        cfg = 1'b0;
    logic        man_rdy = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        rnd_rdy = 1'b1;
    logic        out_ready;

    logic        rdy32, rdy64, ov32, ov64, hit32, hit64;
    logic [31:0] od32;
    logic [63:0] od64;
    logic        obs_ready, obs_valid, obs_hit;
    logic [63:0] obs_data;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic seen = 1'b0;

    logic        mvld [2];
    logic [63:0] mmask [2];
    logic        mop [2];

    assign out_ready = rand_rdy ? rnd_rdy : man_rdy;
    assign obs_ready = cfg ? rdy64 : rdy32;
    assign obs_valid = cfg ? ov64 : ov32;
    assign obs_hit   = cfg ? hit64 : hit32;
    assign obs_data  = cfg ? od64 : {32'h0, od32};

    rvbmu_seq #(.XLEN(32), .SPC(1), .CACHE_EN(1'b1)) u_dut32 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid && !cfg),
        .in_ready (rdy32),
        .in_op    (in_op),
        .in_data  (in_data[31:0]),
        .in_mask  (in_mask[31:0]),
        .out_valid(ov32),
        .out_ready(out_ready),
        .out_data (od32),
        .out_hit  (hit32)
    );

    rvbmu_seq #(.XLEN(64), .SPC(2), .CACHE_EN(1'b1)) u_dut64 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid && cfg),
        .in_ready (rdy64),
        .in_op    (in_op),
        .in_data  (in_data),
        .in_mask  (in_mask),
        .out_valid(ov64),
        .out_ready(out_ready),
        .out_data (od64),
        .out_hit  (hit64)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_rdy <= ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_bext(logic [63:0] d, logic [63:0] m,
                                             int w);
        logic [63:0] r = '0;
        int k = 0;
        for (int i = 0; i < w; i++)
            if (m[i]) begin
                r[k] = d[i];
                k++;
            end
        return r;
    endfunction

    function automatic logic [63:0] ref_bdep(logic [63:0] d, logic [63:0] m,
                                             int w);
        logic [63:0] r = '0;
        int k = 0;
        for (int i = 0; i < w; i++)
            if (m[i]) begin
                r[i] = d[k];
                k++;
            end
        return r;
    endfunction

    function automatic logic [63:0] ref_op(logic op, logic [63:0] d,
                                           logic [63:0] m, int w);
        return op ? ref_bdep(d, m, w) : ref_bext(d, m, w);
    endfunction

    task automatic send(input logic op, input logic [63:0] d,
                        input logic [63:0] m, input logic [63:0] exp);
        exp_t e;
        int   n;
        int   p;
        logic h;
        if (!cfg) begin
            d[63:32] = '0;
            m[63:32] = '0;
        end
        p = cfg ? P64 : P32;
        @(posedge clk);
        #1;
        in_op    = op;
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!obs_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!obs_ready) begin
            check("accept_timeout", 64'(obs_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        h = mvld[cfg] && (mmask[cfg] == m) && (mop[cfg] == op);
        mvld[cfg]  = 1'b1;
        mmask[cfg] = m;
        mop[cfg]   = op;
        e.data  = exp;
        e.hit   = h;
        e.lat   = h ? p + 1 : 2 * p + 1;
        e.t_acc = cyc - 1;
        sb.push_back(e);
    endtask

    task automatic send_ref(input logic op, input logic [63:0] d,
                            input logic [63:0] m);
        send(op, d, m, ref_op(op, d, m, cfg ? 64 : 32));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (obs_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(obs_valid), 64'd0);
            end else begin
                if (!seen)
                    check("latency", 64'(cyc - sb[0].t_acc), 64'(sb[0].lat));
                seen = 1'b1;
                check("out_data", obs_data, sb[0].data);
                check("out_hit", 64'(obs_hit), 64'(sb[0].hit));
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [63:0] pool [4];
        logic [63:0] d, m;
        logic        op, bad;
        int          n;

        mvld[0] = 1'b0;
        mvld[1] = 1'b0;
        mmask[0] = '0;
        mmask[1] = '0;
        mop[0] = 1'b0;
        mop[1] = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rdy32_in_reset", 64'(rdy32), 64'd0);
        check("rdy64_in_reset", 64'(rdy64), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rdy32_after_reset", 64'(rdy32), 64'd1);
        check("rdy64_after_reset", 64'(rdy64), 64'd1);
        check("valid32_reset", 64'(ov32), 64'd0);
        check("data32_reset", 64'(od32), 64'd0);
        check("hit32_reset", 64'(hit32), 64'd0);
        check("valid64_reset", 64'(ov64), 64'd0);

        send(1'b0, 64'hDEADBEEF, 64'h0000FF00, 64'h000000BE);
        send(1'b0, 64'h12345678, 64'h0000FF00, 64'h00000056);
        send(1'b1, 64'h000000A5, 64'h0000FF00, 64'h0000A500);
        send(1'b1, 64'h000000A5, 64'hF0F00000, 64'hA0500000);
        send(1'b0, 64'hDEADBEEF, 64'h00000000, 64'h0);
        send(1'b1, 64'hDEADBEEF, 64'h00000000, 64'h0);
        send(1'b0, 64'hCAFEF00D, 64'hFFFFFFFF, 64'hCAFEF00D);
        send(1'b1, 64'hCAFEF00D, 64'hFFFFFFFF, 64'hCAFEF00D);
        wait_idle();

        man_rdy = 1'b0;
        send_ref(1'b0, 64'h13579BDF, 64'h0F0F0F0F);
        n = 0;
        while (!obs_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", 64'(obs_valid), 64'd1);
        repeat (4) begin
            @(negedge clk);
            check("ready_in_done", 64'(obs_ready), 64'd0);
        end
        man_rdy = 1'b1;
        wait_idle();

        send_ref(1'b0, 64'hFFFF0000, 64'h00FF00FF);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        mvld[0] = 1'b0;
        mvld[1] = 1'b0;
        @(negedge clk);
        check("rdy_mid_reset", 64'(obs_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_abort", 64'(obs_ready), 64'd1);
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (obs_valid) bad = 1'b1;
        end
        check("no_valid_after_abort", 64'(bad), 64'd0);
        send_ref(1'b0, 64'hFFFF0000, 64'h00FF00FF);
        wait_idle();

        cfg = 1'b1;
        send(1'b0, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF,
             64'h0123456789ABCDEF);
        send(1'b1, 64'h0000000000000003, 64'h8000000000000001,
             64'h8000000000000001);
        send(1'b1, 64'h0000000000000002, 64'h8000000000000001,
             64'h8000000000000000);
        wait_idle();

        pool[0] = '0;
        pool[1] = '1;
        pool[2] = {$urandom, $urandom};
        pool[3] = {$urandom, $urandom};
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            op = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                m = pool[$urandom_range(0, 3)];
            else
                m = {$urandom, $urandom};
            d = {$urandom, $urandom};
            send_ref(op, d, m);
        end
        wait_idle();
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
